ecc_rmw_ctrl: RTL
=================

ECC_RMW_CTRL -- requirements
Module: ecc_rmw_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, memory word address width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16, read-response timeout in clk cycles (used only when ECC_RMW_TIMEOUT_EN is defined).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  write request valid.
REQ-006 SHALL have port req_ready  output  1  request accept; transfer when req_valid && req_ready.
REQ-007 SHALL have ports req_addr  input  ADDR_WIDTH, req_wdata  input  64, req_be  input  8  (bit i enables byte i = data[8i+7:8i]).
REQ-008 SHALL have ports enc_data  output  64 (to SEC/DED encoder) and enc_ecc  input  8 (encoder result, combinational, same cycle).
REQ-009 SHALL have ports mem_en  output  1, mem_we  output  1, mem_addr  output  ADDR_WIDTH, mem_wdata  output  64, mem_wecc  output  8, mem_gnt  input  1  (command accepted when mem_en && mem_gnt).
REQ-010 SHALL have ports mem_rvalid  input  1, mem_rdata  input  64  (read data, any latency >= 1 cycle after read grant).
REQ-011 SHALL have ports done  output  1  (one-cycle completion pulse) and err  output  1  (qualified by done).
REQ-012 SHALL have port timeout_flag  output  1  (sticky).

Function
REQ-013 SHALL implement FSM states IDLE, RD, WAIT, WR, DONE.
REQ-014 SHALL assert req_ready only in IDLE; requests are never queued.
REQ-015 SHALL, on acceptance, register addr, wdata, be; next state: be==8'h00 -> DONE (no memory access); be==8'hFF -> WR with merge_q=req_wdata; else RD.
REQ-016 SHALL in RD drive mem_en=1, mem_we=0, mem_addr=addr_q, held until mem_gnt; on grant -> WAIT.
REQ-017 SHALL in WAIT, on mem_rvalid, load merge_q byte i = be_q[i] ? wdata_q byte i : mem_rdata byte i, then -> WR; mem_rvalid outside WAIT is ignored.
REQ-018 SHALL drive enc_data=merge_q at all times; in WR drive mem_en=1, mem_we=1, mem_addr=addr_q, mem_wdata=merge_q, mem_wecc=enc_ecc, held stable until mem_gnt; on grant -> DONE.
REQ-019 SHALL in DONE assert done=1 for exactly one cycle, err per REQ-024, then -> IDLE.
REQ-020 SHALL drive mem_en=0, mem_we=0 in IDLE, WAIT, DONE; mem_we never high without mem_en.
REQ-021 Latency (zero-wait gnt, read data 1 cycle after read grant): full write done at T+2, partial write done at T+4, be==0 done at T+1, T = acceptance cycle.

Reset
REQ-022 SHALL on rst_n low asynchronously force IDLE and clear merge_q, addr_q, wdata_q, be_q, counters; outputs req_ready=0 while rst_n low, then 1; mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0, err=0, timeout_flag=0.
REQ-023 SHALL abandon any in-flight request on reset mid-operation with no done pulse; a read response arriving after reset release is ignored.

Configuration
REQ-024 With ECC_RMW_TIMEOUT_EN defined: SHALL count cycles in WAIT; if mem_rvalid absent after TIMEOUT_CYCLES cycles -> DONE with err=1, no write issued, timeout_flag set until reset; err=0 otherwise.
REQ-025 Without ECC_RMW_TIMEOUT_EN: SHALL wait in WAIT indefinitely; err and timeout_flag tied to 0; no counter logic.

Verification
REQ-026 Full write: addr=16'h0010, wdata=64'h0123_4567_89AB_CDEF, be=8'hFF, gnt=1 -> one write, no read, mem_wdata=wdata, mem_wecc=encoder(wdata), done at T+2, err=0.
REQ-027 Partial write: memory holds 64'hFFFF_FFFF_FFFF_FFFF, wdata=64'h0, be=8'h0F -> read then write of 64'hFFFF_FFFF_0000_0000 with matching ecc, done at T+4.
REQ-028 Stalled grant: mem_gnt low 5 cycles during WR -> mem_addr/mem_wdata/mem_wecc stable throughout, single write on grant.
REQ-029 be=8'h00 -> no mem_en ever, done at T+1, err=0; req_ready low T+1, high T+2.
REQ-030 Timeout (macro defined, TIMEOUT_CYCLES=16): no mem_rvalid -> done with err=1 after 16 WAIT cycles, no write, timeout_flag=1 until rst_n low.
REQ-031 rst_n low asynchronously while in WAIT -> immediate IDLE outputs, no done, late mem_rvalid ignored, next request completes normally.

Source files
------------

// File: rtl/ecc_rmw_ctrl.sv
// rtl/ecc_rmw_ctrl.sv - ECC read-modify-write controller for byte-masked 64-bit writes (option: ECC_RMW_TIMEOUT_EN)
module ecc_rmw_ctrl #(
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [63:0]           req_wdata,
    input  logic [7:0]            req_be,
    output logic [63:0]           enc_data,
    input  logic [7:0]            enc_ecc,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [63:0]           mem_wdata,
    output logic [7:0]            mem_wecc,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [63:0]           mem_rdata,
    output logic                  done,
    output logic                  err,
    output logic                  timeout_flag
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WAIT = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } state_t;

    // The read-response counter needs at least one cycle of patience.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_range_check
        $error("ecc_rmw_ctrl: TIMEOUT_CYCLES must be at least 1");
    end

    state_t                  state_q;
    state_t                  state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [63:0]             wdata_q;
    logic [7:0]              be_q;
    logic [63:0]             merge_q;
    logic [63:0]             rmw_merge;
    logic                    accept;
    logic                    rd_resp;

    assign accept   = req_valid && req_ready;
    // Read data is only meaningful while a read is outstanding; stray beats elsewhere are dropped.
    assign rd_resp  = (state_q == WAIT) && mem_rvalid;
    assign enc_data = merge_q;

`ifdef ECC_RMW_TIMEOUT_EN
    localparam int                CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt_q;
    logic             err_q;
    logic             timeout_q;
    logic             expire;

    // Last allowed WAIT cycle passed with no response: give up on the write.
    assign expire = (state_q == WAIT) && !mem_rvalid && (wait_cnt_q == CNT_LAST);

    // Count cycles spent in WAIT; latch the error for the DONE pulse and the sticky flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            if (state_q == WAIT) begin
                wait_cnt_q <= wait_cnt_q + 1'b1;
            end else begin
                wait_cnt_q <= '0;
            end
            if (accept) begin
                err_q <= 1'b0;
            end else if (expire) begin
                err_q <= 1'b1;
            end
            if (expire) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign err          = (state_q == DONE) && err_q;
    assign timeout_flag = timeout_q;
`else
    assign err          = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    // Byte merge of old memory contents with the enabled bytes of the new data.
    always_comb begin
        rmw_merge = mem_rdata;
        for (int i = 0; i < 8; i++) begin
            if (be_q[i]) begin
                rmw_merge[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request capture and the merged word that feeds the encoder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            merge_q <= '0;
        end else begin
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
                if (req_be == 8'hFF) begin
                    merge_q <= req_wdata;
                end
            end else if (rd_resp) begin
                merge_q <= rmw_merge;
            end
        end
    end

    // Next-state logic: full writes skip the read, empty masks skip memory entirely.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_be == 8'h00) begin
                        state_d = DONE;
                    end else if (req_be == 8'hFF) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                if (mem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_d = WR;
                end
`ifdef ECC_RMW_TIMEOUT_EN
                else if (expire) begin
                    state_d = DONE;
                end
`endif
            end
            WR: begin
                if (mem_gnt) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory command and handshake outputs; commands hold steady until granted.
    always_comb begin
        req_ready = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wecc  = '0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = rst_n;
            end
            RD: begin
                mem_en   = 1'b1;
                mem_addr = addr_q;
            end
            WR: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = merge_q;
                mem_wecc  = enc_ecc;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
